// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operand handshake in,
// result handshake out.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             overflow;

    // master: the datapath/controller issuing requests and consuming results
    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result, zero, negative, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result, zero, negative, overflow
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus an iterative shift-add
// multiplier retiring MUL_BITS multiplier bits per cycle.
module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic     clk,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg,  state_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               zero_reg,   zero_next;
    logic               neg_reg,    neg_next;
    logic               ovf_reg,    ovf_next;
    logic [WIDTH-1:0]   acc_reg,    acc_next;
    logic [WIDTH-1:0]   mcand_reg,  mcand_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;

    logic               in_ready;
    logic               accept;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   partial;
    logic [WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]   pp [MUL_BITS];

    assign in_ready = (state_reg == IDLE) || (state_reg == DONE && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // One shifted copy of the multiplicand per multiplier bit retired this step
    for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
        assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            partial = partial + pp[i];
        end
    end

    assign acc_sum = acc_reg + partial;

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    // SLT uses a true signed compare so it cannot suffer from subtract overflow
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_control)
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_NOR: alu_res = ~(bus.a | bus.b);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        neg_next    = neg_reg;
        ovf_next    = ovf_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    if (bus.alu_control == OP_MUL) begin
                        state_next  = BUSY;
                        acc_next    = '0;
                        mcand_next  = bus.a;
                        mplier_next = bus.b;
                        cnt_next    = CNT_W'(STEPS);
                    end else begin
                        state_next  = DONE;
                        result_next = alu_res;
                        zero_next   = (alu_res == '0);
                        neg_next    = alu_res[WIDTH-1];
                        ovf_next    = alu_ovf;
                    end
                end else if (state_reg == DONE && bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                acc_next    = acc_sum;
                mcand_next  = mcand_reg << MUL_BITS;
                mplier_next = mplier_reg >> MUL_BITS;
                cnt_next    = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next  = DONE;
                    result_next = acc_sum;
                    zero_next   = (acc_sum == '0);
                    neg_next    = acc_sum[WIDTH-1];
                    ovf_next    = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            neg_reg    <= neg_next;
            ovf_reg    <= ovf_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.negative  = neg_reg;
    assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit/1-bit-per-step instance and an
// 8-bit/4-bits-per-step instance.
module tb_alu_mc;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus32 ();
    alu_mc_if #(.WIDTH(8))  bus8 ();

    alu_mc #(.WIDTH(32), .MUL_BITS(1)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_mc #(.WIDTH(8),  .MUL_BITS(4)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s = 0x%08h", name, act);
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.alu_control = op;
        bus32.a = a;
        bus32.b = b;
        bus32.in_valid = 1'b1;
    endtask

    // MUL with a competing ADD request held during BUSY and a stalled consumer
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int k;
        int busy_ready;
        check("mul_in_ready_idle", {31'b0, bus32.in_ready}, 32'd1);
        drive32(OP_MUL, a, b);
        wait_edge();
        drive32(OP_ADD, 32'd1, 32'd1);
        bus32.out_ready = 1'b0;
        k = 0;
        busy_ready = 0;
        while (bus32.out_valid !== 1'b1 && k < 100) begin
            if (bus32.in_ready !== 1'b0) busy_ready++;
            wait_edge();
            k++;
        end
        check("mul_latency", k, 32'd32);
        check("mul_busy_in_ready_seen", busy_ready, 32'd0);
        check("mul_result", bus32.result, exp);
        check("mul_zero", {31'b0, bus32.zero}, {31'b0, exp == 32'd0});
        check("mul_overflow", {31'b0, bus32.overflow}, 32'd0);
        bus32.out_ready = 1'b1;
        wait_edge();
        check("mul_then_add_result", bus32.result, 32'd2);
        check("mul_then_add_valid", {31'b0, bus32.out_valid}, 32'd1);
        bus32.in_valid = 1'b0;
        wait_edge();
        check("mul_then_idle", {31'b0, bus32.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        int   k;

        vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{OP_AND, 32'h000000F0, 32'h0000000F, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{OP_OR,  32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_XOR, 32'h0000FF00, 32'h00000FF0, 32'h0000F0F0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{OP_SLT, 32'hFFFFFFFD, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_SLT, 32'h00000002, 32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1};

        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.alu_control = '0;
        bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.alu_control = '0;
        bus8.out_ready = 1'b1;

        // Reset state
        wait_edge();
        wait_edge();
        check("rst_out_valid", {31'b0, bus32.out_valid}, 32'd0);
        check("rst_result", bus32.result, 32'd0);
        check("rst_flags", {29'b0, bus32.zero, bus32.negative, bus32.overflow}, 32'd0);
        reset = 1'b0;
        wait_edge();
        check("post_rst_in_ready", {31'b0, bus32.in_ready}, 32'd1);

        // Single-cycle ops issued back-to-back, one per cycle
        for (int i = 0; i < 13; i++) begin
            drive32(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_edge();
            check($sformatf("vec%0d_valid", i), {31'b0, bus32.out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), bus32.result, vecs[i].res);
            check($sformatf("vec%0d_znv", i),
                  {29'b0, bus32.zero, bus32.negative, bus32.overflow},
                  {29'b0, vecs[i].z, vecs[i].n, vecs[i].v});
        end
        bus32.in_valid = 1'b0;
        wait_edge();
        check("table_then_idle", {31'b0, bus32.out_valid}, 32'd0);

        // Iterative multiply
        run_mul(32'h00010001, 32'h00010001, 32'h00020001);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // Backpressure: result held while out_ready=0, new inputs ignored
        bus32.out_ready = 1'b0;
        drive32(OP_SLT, 32'hFFFFFFFD, 32'h00000002);
        wait_edge();
        for (int i = 0; i < 5; i++) begin
            drive32(OP_ADD, 32'd10 + i, 32'd20);
            #1;
            check($sformatf("bp%0d_valid", i), {31'b0, bus32.out_valid}, 32'd1);
            check($sformatf("bp%0d_in_ready", i), {31'b0, bus32.in_ready}, 32'd0);
            wait_edge();
            check($sformatf("bp%0d_result", i), bus32.result, 32'd1);
        end
        drive32(OP_ADD, 32'd100, 32'd20);
        bus32.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'b0, bus32.in_ready}, 32'd1);
        wait_edge();
        check("bp_release_result", bus32.result, 32'd120);
        check("bp_release_valid", {31'b0, bus32.out_valid}, 32'd1);
        bus32.in_valid = 1'b0;
        wait_edge();

        // Reset in the middle of a multiply
        drive32(OP_MUL, 32'h00010001, 32'h00010001);
        wait_edge();
        bus32.in_valid = 1'b0;
        repeat (10) wait_edge();
        reset = 1'b1;
        #1;
        check("midmul_rst_valid", {31'b0, bus32.out_valid}, 32'd0);
        check("midmul_rst_result", bus32.result, 32'd0);
        check("midmul_rst_in_ready", {31'b0, bus32.in_ready}, 32'd1);
        wait_edge();
        reset = 1'b0;
        drive32(OP_ADD, 32'd2, 32'd3);
        wait_edge();
        check("post_rst_add_valid", {31'b0, bus32.out_valid}, 32'd1);
        check("post_rst_add_result", bus32.result, 32'd5);
        bus32.in_valid = 1'b0;
        wait_edge();
        check("post_rst_add_idle", {31'b0, bus32.out_valid}, 32'd0);

        // 8-bit instance, 4 multiplier bits per step
        bus8.alu_control = OP_MUL; bus8.a = 8'h13; bus8.b = 8'h11; bus8.in_valid = 1'b1;
        wait_edge();
        bus8.in_valid = 1'b0;
        k = 0;
        while (bus8.out_valid !== 1'b1 && k < 100) begin
            wait_edge();
            k++;
        end
        check("w8_mul_latency", k, 32'd2);
        check("w8_mul_result", {24'b0, bus8.result}, 32'h43);
        bus8.alu_control = OP_ADD; bus8.a = 8'h80; bus8.b = 8'h80; bus8.in_valid = 1'b1;
        wait_edge();
        bus8.in_valid = 1'b0;
        check("w8_add_result", {24'b0, bus8.result}, 32'h00);
        check("w8_add_znv", {29'b0, bus8.zero, bus8.negative, bus8.overflow}, 32'b101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
